pipelined_inner_product_test: RTL and testbench
===============================================

Name: pipelined_inner_product_test

Overview:
- Self-stimulating test wrapper around a pipelined inner-product datapath.
- A free-running counter generates the input vector: NUM_ELEMS elements, DATA_WIDTH bits each.
- The block computes the inner product of that vector with itself (sum of squares) through a 2-stage pipeline.
- It outputs the result together with the counter value that produced it, pipeline-aligned, so a bench can check each (input, result) pair on every clock.

Parameters:
- DATA_WIDTH, 3, bits per vector element.
- NUM_ELEMS, 3, number of vector elements; counter width = DATA_WIDTH*NUM_ELEMS (9).
- OUT_WIDTH, 8, result width.
  - Must satisfy OUT_WIDTH >= 2*DATA_WIDTH + ceil(log2(NUM_ELEMS)).
  - Defaults: max result 3*49 = 147, which fits in 8 bits.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  reset, asynchronous and active-high; clears all registers.
- outp  output  OUT_WIDTH (8)  registered inner-product result.
- outp_inps  output  DATA_WIDTH*NUM_ELEMS (9)  counter value (input vector) that produced the current outp.

Behaviour:
- Reset (rst=1, asynchronous assert):
  - Counter, stage-1 product registers, stage-1 delayed count, outp and outp_inps all become 0.
  - Holds while rst=1. Deassertion is taken at a clock edge.
- Counter cnt: +1 every rising edge when rst=0, modulo 2^(DATA_WIDTH*NUM_ELEMS). It wraps 511 -> 0 with no stall or flag.
- Element unpacking: element i = cnt[DATA_WIDTH*i + DATA_WIDTH-1 : DATA_WIDTH*i]. Element 0 is the LSBs. All values are unsigned.
- Stage 1 (registered):
  - p_i <= element_i * element_i, each 2*DATA_WIDTH bits (6).
  - cnt_d1 <= cnt.
- Stage 2 (registered):
  - outp <= sum of all p_i, zero-extended to OUT_WIDTH.
  - outp_inps <= cnt_d1.
- Latency: 2 clocks from a value appearing on cnt to its result on outp.
  - outp and outp_inps always change on the same edge and always form a consistent pair: outp == sum over i of (outp_inps element i)^2.
- After reset release, the output pairs per cycle are:
  - (inps=0, outp=0) for three consecutive samples;
  - then (1,1), (2,4), (3,9), (4,16), ...
- No overflow is possible at the default parameters. For other parameters the width constraint above is mandatory; no saturation is performed.
- Reset mid-operation: all state returns to 0 immediately. The sequence restarts from count 0 exactly as after power-on reset.
- No handshake: outputs are valid every cycle, including the reset state, since 0 maps to 0.

Decomposition:
- Shared package holds:
  - DATA_WIDTH, NUM_ELEMS, OUT_WIDTH defaults;
  - derived VEC_WIDTH = DATA_WIDTH*NUM_ELEMS;
  - PROD_WIDTH = 2*DATA_WIDTH.
- One sub-module: pipelined_inner_product, the generic 2-stage square/multiply-and-sum core.
  - Ports: clk, rst, vector input, result output.
  - Parameterised on the package constants.
- The top contains the counter, the count delay line aligned to the core latency, and the core instance.

Test Plan:
- Reset then release, sample at each posedge -> pairs (0,0),(0,0),(0,0),(1,1),(2,4),(3,9),(4,16),(5,25),(6,36),(7,49),(8,1).
- Count 9'o123 (83; elements 3,2,1) -> outp_inps=83, outp=14. Count 9'o070 (56) -> outp=49.
- Count 511 (all elements 7) -> outp=147 (max, no overflow). Next counts 0 and 1 -> outp=0, then 1, confirming wrap-around.
- Assert rst asynchronously between edges at count ~200 -> outp and outp_inps become 0 immediately. After release, the sequence matches scenario 1.
- Run 1100 cycles with a bench model computing the sum of squares of the outp_inps fields -> outp matches on every cycle, with no mismatch across both wraps.

Source files
------------

// File: rtl/pipelined_inner_product_test_pkg.sv
// Shared constants for the self-stimulating inner-product test wrapper.
// The width rule OUT_WIDTH >= 2*DATA_WIDTH + ceil(log2(NUM_ELEMS)) must hold
// for any override, because the adder tree never saturates.
package pipelined_inner_product_test_pkg;

    localparam int DATA_WIDTH = 3;
    localparam int NUM_ELEMS  = 3;
    localparam int OUT_WIDTH  = 8;

    localparam int VEC_WIDTH  = DATA_WIDTH * NUM_ELEMS;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

endpackage

// File: rtl/pipelined_inner_product_test_core.sv
// Generic 2-stage sum-of-squares core.
// Stage 1 squares every element of the packed vector.
// Stage 2 adds the squares into the result register.
module pipelined_inner_product
    import pipelined_inner_product_test_pkg::*;
#(
    parameter int P_DATA_WIDTH = DATA_WIDTH,
    parameter int P_NUM_ELEMS  = NUM_ELEMS,
    parameter int P_OUT_WIDTH  = OUT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_DATA_WIDTH*P_NUM_ELEMS-1:0] vec,
    output logic [P_OUT_WIDTH-1:0]              result
);

    localparam int P_PROD_WIDTH = 2 * P_DATA_WIDTH;

    logic [P_PROD_WIDTH-1:0] prod_next [P_NUM_ELEMS];
    logic [P_PROD_WIDTH-1:0] prod      [P_NUM_ELEMS];
    logic [P_OUT_WIDTH-1:0]  sum_next;

    // Square each unsigned element; element 0 sits in the vector LSBs.
    always_comb begin
        for (int i = 0; i < P_NUM_ELEMS; i++) begin
            prod_next[i] = P_PROD_WIDTH'(vec[P_DATA_WIDTH*i +: P_DATA_WIDTH])
                         * P_PROD_WIDTH'(vec[P_DATA_WIDTH*i +: P_DATA_WIDTH]);
        end
    end

    // Stage 1: register the squares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P_NUM_ELEMS; i++) begin
                prod[i] <= '0;
            end
        end else begin
            for (int i = 0; i < P_NUM_ELEMS; i++) begin
                prod[i] <= prod_next[i];
            end
        end
    end

    // Add the registered squares.
    // Each square is zero-extended to the output width before it is added.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < P_NUM_ELEMS; i++) begin
            sum_next = sum_next + P_OUT_WIDTH'(prod[i]);
        end
    end

    // Stage 2: register the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= sum_next;
        end
    end

endmodule

// File: rtl/pipelined_inner_product_test.sv
// Test wrapper: a free-running counter feeds the inner-product core.
// The count is delayed to match the core latency, so the outputs always
// carry a (vector, result) pair that belong together.
module pipelined_inner_product_test
    import pipelined_inner_product_test_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [OUT_WIDTH-1:0]  outp,
    output logic [VEC_WIDTH-1:0]  outp_inps
);

    logic [VEC_WIDTH-1:0] cnt;
    logic [VEC_WIDTH-1:0] cnt_d1;

    // The counter wraps silently to 0 after its all-ones value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + VEC_WIDTH'(1);
        end
    end

    // Delay the count by two stages, matching the two register stages in the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_d1    <= '0;
            outp_inps <= '0;
        end else begin
            cnt_d1    <= cnt;
            outp_inps <= cnt_d1;
        end
    end

    pipelined_inner_product #(
        .P_DATA_WIDTH (DATA_WIDTH),
        .P_NUM_ELEMS  (NUM_ELEMS),
        .P_OUT_WIDTH  (OUT_WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .vec    (cnt),
        .result (outp)
    );

endmodule

// File: tb/tb_pipelined_inner_product_test.sv
// Self-checking bench for pipelined_inner_product_test.
// A queue models the count delay line.
// A local function recomputes the sum of squares of each expected count.
module tb_pipelined_inner_product_test;
    import pipelined_inner_product_test_pkg::*;

    logic                 tb_clk = 1'b0;
    logic                 rst;
    logic [OUT_WIDTH-1:0] outp;
    logic [VEC_WIDTH-1:0] outp_inps;

    int total = 0;
    int bad   = 0;

    logic [VEC_WIDTH-1:0] model_cnt;
    logic [VEC_WIDTH-1:0] prev_exp;
    logic [VEC_WIDTH-1:0] pipe_q [$];

    // Expected pairs after reset: the reset state, then 10 clock edges.
    int table_inps [11] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    int table_outp [11] = '{0, 0, 0, 1, 4, 9, 16, 25, 36, 49, 1};

    pipelined_inner_product_test dut (
        .clk       (tb_clk),
        .rst       (rst),
        .outp      (outp),
        .outp_inps (outp_inps)
    );

    always #5 tb_clk = ~tb_clk;

    // Sum of squares of the unsigned 3-bit fields of a count.
    function automatic int sum_sq(input logic [VEC_WIDTH-1:0] v);
        int s;
        int e;
        s = 0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            e = (int'(v) >> (DATA_WIDTH * i)) & ((1 << DATA_WIDTH) - 1);
            s = s + e * e;
        end
        return s;
    endfunction

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // The delay line holds the single zero in cnt_d1 when the counter restarts.
    task automatic modelReset();
        pipe_q.delete();
        pipe_q.push_back('0);
        model_cnt = '0;
        prev_exp  = '0;
    endtask

    // Advance one clock edge, mirror the count into the delay-line model,
    // then wait until the outputs have settled.
    task automatic applyStimulus();
        @(posedge tb_clk);
        pipe_q.push_back(model_cnt);
        model_cnt = model_cnt + 1'b1;
        #1;
    endtask

    // Compare the current output pair against the head of the delay line.
    task automatic checkOutput();
        logic [VEC_WIDTH-1:0] exp_inps;
        if (pipe_q.size() == 0) begin
            compare("queue_empty", 32'(pipe_q.size()), 32'd1);
        end else begin
            exp_inps = pipe_q.pop_front();
            compare("pair_inps", 32'(outp_inps), 32'(exp_inps));
            compare("pair_outp", 32'(outp), 32'(sum_sq(exp_inps)));
            if (exp_inps == 9'o123) compare("oct123", 32'(outp), 32'd14);
            if (exp_inps == 9'o070) compare("oct070", 32'(outp), 32'd49);
            if (exp_inps == 9'd511) compare("max_147", 32'(outp), 32'd147);
            if (prev_exp == 9'd511 && exp_inps == 9'd0) compare("wrap_zero", 32'(outp), 32'd0);
            if (prev_exp == 9'd0 && exp_inps == 9'd1) compare("wrap_one", 32'(outp), 32'd1);
            prev_exp = exp_inps;
        end
    endtask

    // Check the reset state, then the first 10 edges against the fixed table.
    task automatic checkStartSequence();
        compare("start_inps_0", 32'(outp_inps), 32'(table_inps[0]));
        compare("start_outp_0", 32'(outp), 32'(table_outp[0]));
        for (int i = 1; i < 11; i++) begin
            applyStimulus();
            compare("start_inps", 32'(outp_inps), 32'(table_inps[i]));
            compare("start_outp", 32'(outp), 32'(table_outp[i]));
            checkOutput();
        end
    endtask

    initial begin
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge tb_clk);
        #1;
        compare("reset_outp", 32'(outp), 32'd0);
        compare("reset_inps", 32'(outp_inps), 32'd0);

        @(negedge tb_clk);
        rst = 1'b0;
        modelReset();
        checkStartSequence();

        // Run until outp_inps reaches 200.
        repeat (192) begin
            applyStimulus();
            checkOutput();
        end
        compare("pre_reset_inps", 32'(outp_inps), 32'd200);

        // Assert reset between clock edges; the outputs must clear at once.
        #2;
        rst = 1'b1;
        #1;
        compare("async_outp", 32'(outp), 32'd0);
        compare("async_inps", 32'(outp_inps), 32'd0);
        @(posedge tb_clk);
        @(negedge tb_clk);
        rst = 1'b0;
        modelReset();
        checkStartSequence();

        // Long run covering two counter wraps.
        repeat (1090) begin
            applyStimulus();
            checkOutput();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
